video_line_fetcher: RTL and testbench

- Pixel source directly upstream of the VGA timing/colour stage; produces its 12-bit Pix_color from that stage's H_count/V_count.
- Displays a 640x480 RGB444 camera frame, read from the frame-buffer memory, centred in the 800x600 raster; everything outside the image is BORDER colour.
- Two ping-pong line buffers. Each image row is burst-fetched during the display line before it is shown.

---
 rtl/video_line_fetcher.sv | 184 ++++++++++++++++++
 tb/tb_video_line_fetcher.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_line_fetcher.sv
// Line-buffered pixel source: burst-fetches each camera row into one of two
// ping-pong buffers one line ahead, and shows it centred in the raster with a border.
module video_line_fetcher #(
  parameter int          IMG_W   = 640,
  parameter int          IMG_H   = 480,
  parameter int          H_OFS   = 80,
  parameter int          V_OFS   = 60,
  parameter logic [18:0] FB_BASE = 19'd0,
  parameter logic [11:0] BORDER  = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] H_count,
  input  logic [10:0] V_count,
  output logic [11:0] Pix_color,
  output logic        mem_req,
  output logic [18:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [11:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        fetch_err
);

  localparam logic [10:0] H_LO    = 11'(H_OFS);
  localparam logic [10:0] H_HI    = 11'(H_OFS + IMG_W - 1);
  localparam logic [10:0] V_LO    = 11'(V_OFS);
  localparam logic [10:0] V_HI    = 11'(V_OFS + IMG_H - 1);
  localparam logic [10:0] TRIG_LO = 11'(V_OFS - 1);
  localparam logic [10:0] TRIG_HI = 11'(V_OFS + IMG_H - 2);
  localparam logic [9:0]  W10     = 10'(IMG_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_r;
  logic [9:0]  issued_r;
  logic [9:0]  received_r;
  logic [9:0]  row_r;
  logic [9:0]  pend_row_r;
  logic [11:0] lb0_r [0:IMG_W-1];
  logic [11:0] lb1_r [0:IMG_W-1];

  logic        hit_s;
  logic        rd_buf_s;
  logic        trig_s;
  logic        grant_s;
  logic        beat_s;
  logic        wr_en_s;
  logic        done_s;
  logic        drained_s;
  logic [9:0]  col_s;
  logic [9:0]  row_s;
  logic [9:0]  issued_nx_s;
  logic [9:0]  received_nx_s;
  logic [18:0] row_addr_s;
  logic [18:0] pend_addr_s;

  // Window decode, fetch trigger and next-count arithmetic
  always_comb begin
    hit_s         = (H_count >= H_LO) && (H_count <= H_HI) &&
                    (V_count >= V_LO) && (V_count <= V_HI);
    col_s         = 10'(H_count - H_LO);
    rd_buf_s      = V_count[0] ^ V_LO[0];
    trig_s        = (H_count == 11'd0) && (V_count >= TRIG_LO) && (V_count <= TRIG_HI);
    row_s         = 10'(V_count - V_LO + 11'd1);
    // Row start is always recomputed, so restarts after errors or reset land correctly
    row_addr_s    = FB_BASE + 19'(row_s) * 19'(IMG_W);
    pend_addr_s   = FB_BASE + 19'(pend_row_r) * 19'(IMG_W);
    grant_s       = mem_req && mem_gnt;
    beat_s        = mem_rvalid && (state_r != IDLE) && (received_r < W10);
    issued_nx_s   = grant_s ? (issued_r + 10'd1) : issued_r;
    received_nx_s = beat_s ? (received_r + 10'd1) : received_r;
    wr_en_s       = beat_s && (state_r == FETCH);
    done_s        = (received_nx_s == W10);
    drained_s     = (received_nx_s == issued_r);
  end

  // Line-buffer write port: returned words land in the buffer of the row in flight
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      if (row_r[0]) begin
        lb1_r[received_r] <= mem_rdata;
      end else begin
        lb0_r[received_r] <= mem_rdata;
      end
    end
  end

  // Pixel output: synchronous buffer read inside the window, border elsewhere
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Pix_color <= 12'h000;
    end else if (!hit_s) begin
      Pix_color <= BORDER;
    end else if (rd_buf_s) begin
      Pix_color <= lb1_r[col_s];
    end else begin
      Pix_color <= lb0_r[col_s];
    end
  end

  // Fetch controller with registered memory-side outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      issued_r   <= 10'd0;
      received_r <= 10'd0;
      row_r      <= 10'd0;
      pend_row_r <= 10'd0;
      mem_req    <= 1'b0;
      mem_addr   <= 19'd0;
      fetch_err  <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (trig_s) begin
            state_r    <= FETCH;
            row_r      <= row_s;
            issued_r   <= 10'd0;
            received_r <= 10'd0;
            mem_addr   <= row_addr_s;
            mem_req    <= 1'b1;
          end
        end
        FETCH: begin
          issued_r   <= issued_nx_s;
          received_r <= received_nx_s;
          if (grant_s) begin
            mem_addr <= mem_addr + 19'd1;
          end
          if (trig_s && !done_s) begin
            fetch_err <= 1'b1;
            mem_req   <= 1'b0;
            if (issued_nx_s > received_nx_s) begin
              state_r    <= DRAIN;
              pend_row_r <= row_s;
            end else begin
              row_r      <= row_s;
              issued_r   <= 10'd0;
              received_r <= 10'd0;
              mem_addr   <= row_addr_s;
            end
          end else if (trig_s) begin
            // Previous row completed on the very cycle the next one became due
            row_r      <= row_s;
            issued_r   <= 10'd0;
            received_r <= 10'd0;
            mem_addr   <= row_addr_s;
            mem_req    <= 1'b1;
          end else if (done_s) begin
            state_r <= IDLE;
            mem_req <= 1'b0;
          end else begin
            mem_req <= (issued_nx_s < W10);
          end
        end
        DRAIN: begin
          received_r <= received_nx_s;
          if (trig_s) begin
            fetch_err  <= 1'b1;
            pend_row_r <= row_s;
          end
          if (drained_s) begin
            state_r    <= FETCH;
            row_r      <= trig_s ? row_s : pend_row_r;
            mem_addr   <= trig_s ? row_addr_s : pend_addr_s;
            issued_r   <= 10'd0;
            received_r <= 10'd0;
            mem_req    <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_line_fetcher.sv
// Scoreboard bench for video_line_fetcher: raster driver, randomized memory
// model, and a behavioural model of which image row each buffer holds.
module tb_video_line_fetcher;

  localparam logic [11:0] BORDER_C = 12'hF00;
  localparam int          W        = 640;

  typedef struct packed {
    logic        known;
    logic [11:0] val;
    logic [10:0] h;
    logic [10:0] v;
  } sb_t;

  typedef struct packed {
    logic [31:0] t;
    logic [11:0] d;
  } rt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] H_count;
  logic [10:0] V_count;
  logic [11:0] Pix_color;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_gnt;
  logic [11:0] mem_rdata;
  logic        mem_rvalid;
  logic        fetch_err;

  int          pass_cnt = 0;
  int          tot_cnt  = 0;
  int          err_cnt  = 0;
  int          cyc      = 0;
  int          gmode;
  int          lat;
  int          gnt_block_until;
  int          granted;
  int          bufrow [0:1];
  logic        stim_on;
  logic        addr_chk_on;
  logic [18:0] exp_next_addr;
  logic [11:0] key;
  sb_t         sbq [$];
  rt_t         rq [$];

  video_line_fetcher #(.BORDER(BORDER_C)) dut (
    .clk       (clk),
    .rst       (rst),
    .H_count   (H_count),
    .V_count   (V_count),
    .Pix_color (Pix_color),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic logic [11:0] pat(input logic [18:0] a);
    return a[11:0] ^ key;
  endfunction

  // Expected pixel: border outside the image, else the stored row if the model says it is loaded
  function automatic sb_t expect_px(input int h, input int v);
    sb_t e;
    int  row;
    e.h     = 11'(h);
    e.v     = 11'(v);
    e.known = 1'b1;
    e.val   = BORDER_C;
    if (v >= 60 && v < 540 && h >= 80 && h < 720) begin
      row = v - 60;
      if (bufrow[row % 2] == row) e.val = pat(19'(row * W + h - 80));
      else e.known = 1'b0;
    end
    return e;
  endfunction

  // Memory model: random or blocked grants, in-order returns after `lat` cycles
  initial begin
    logic g;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 12'h000;
    forever begin
      @(negedge clk);
      cyc++;
      if (rq.size() > 0 && int'(rq[0].t) <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rq[0].d;
        void'(rq.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 12'($urandom);
      end
      g = (cyc >= gnt_block_until) && ((gmode == 0) || ($urandom_range(0, 3) != 0));
      mem_gnt = g;
      if (g && mem_req && rst) begin
        rq.push_back('{t: 32'(cyc + lat), d: pat(mem_addr)});
        check("grant_expected", {31'd0, addr_chk_on && (granted < W)}, 32'd1);
        if (addr_chk_on) begin
          check("mem_addr", {13'd0, mem_addr}, {13'd0, exp_next_addr});
          exp_next_addr = exp_next_addr + 19'd1;
          granted++;
        end
      end
    end
  end

  // Monitor: every stimulated cycle yields one pixel one clock later
  initial begin
    logic act;
    sb_t  e;
    forever begin
      @(posedge clk);
      act = stim_on;
      #1;
      if (rst && fetch_err) err_cnt++;
      if (act) begin
        check("sb_level", 32'(sbq.size()), 32'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          if (e.known)
            check($sformatf("pix h=%0d v=%0d", e.h, e.v), {20'd0, Pix_color}, {20'd0, e.val});
        end
      end
    end
  end

  task automatic reset_pulse();
    stim_on = 1'b0;
    rst     = 1'b0;
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_pix", {20'd0, Pix_color}, 32'd0);
    check("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst         = 1'b1;
    bufrow[0]   = -1;
    bufrow[1]   = -1;
    addr_chk_on = 1'b0;
  endtask

  // One full raster line; `good` says the fetch triggered here is expected to land intact
  task automatic drive_line(input int v, input bit good, input bit do_rst);
    bit  rst_done;
    bit  trig_line;
    rst_done  = 1'b0;
    trig_line = (v >= 59 && v <= 538);
    for (int h = 0; h < 1056; h++) begin
      @(negedge clk);
      if (do_rst && !rst_done && granted >= 300) begin
        reset_pulse();
        rst_done = 1'b1;
      end
      H_count = 11'(h);
      V_count = 11'(v);
      if (h == 0 && trig_line) begin
        exp_next_addr = 19'((v - 59) * W);
        granted       = 0;
        addr_chk_on   = 1'b1;
      end
      stim_on = 1'b1;
      sbq.push_back(expect_px(h, v));
    end
    if (trig_line) bufrow[(v - 59) % 2] = (good && !do_rst) ? (v - 59) : -1;
    else check($sformatf("no_req_line%0d", v), {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    int err_base;
    rst             = 1'b0;
    H_count         = 11'd0;
    V_count         = 11'd0;
    stim_on         = 1'b0;
    key             = 12'h000;
    gmode           = 0;
    lat             = 3;
    gnt_block_until = 0;
    granted         = 0;
    addr_chk_on     = 1'b0;
    exp_next_addr   = 19'd0;
    bufrow[0]       = -1;
    bufrow[1]       = -1;
    repeat (3) @(negedge clk);
    check("init_pix", {20'd0, Pix_color}, 32'd0);
    check("init_mem_req", {31'd0, mem_req}, 32'd0);
    check("init_mem_addr", {13'd0, mem_addr}, 32'd0);
    check("init_fetch_err", {31'd0, fetch_err}, 32'd0);
    rst = 1'b1;

    // Ideal memory, word = address[11:0]
    err_base = err_cnt;
    drive_line(58, 1'b1, 1'b0);
    drive_line(59, 1'b1, 1'b0);
    drive_line(60, 1'b1, 1'b0);
    drive_line(61, 1'b1, 1'b0);
    // Last row and the trigger-free region around the frame edge
    drive_line(538, 1'b1, 1'b0);
    drive_line(539, 1'b1, 1'b0);
    drive_line(540, 1'b1, 1'b0);
    drive_line(600, 1'b1, 1'b0);
    drive_line(627, 1'b1, 1'b0);
    drive_line(0, 1'b1, 1'b0);
    drive_line(30, 1'b1, 1'b0);
    check("err_ideal", 32'(err_cnt - err_base), 32'd0);

    // Random grants with 20-cycle returns, random frame contents
    key       = 12'($urandom);
    bufrow[0] = -1;
    bufrow[1] = -1;
    gmode     = 1;
    lat       = 20;
    err_base  = err_cnt;
    drive_line(98, 1'b1, 1'b0);
    drive_line(99, 1'b1, 1'b0);
    check("err_backpressure", 32'(err_cnt - err_base), 32'd0);

    // Starved memory across the line-101 trigger
    gmode           = 0;
    lat             = 3;
    err_base        = err_cnt;
    gnt_block_until = cyc + 1100;
    drive_line(100, 1'b0, 1'b0);
    drive_line(101, 1'b1, 1'b0);
    drive_line(102, 1'b1, 1'b0);
    check("err_starved", 32'(err_cnt - err_base), 32'd1);

    // Slow returns leave beats outstanding at the next trigger
    err_base = err_cnt;
    lat      = 700;
    drive_line(200, 1'b0, 1'b0);
    lat      = 3;
    drive_line(201, 1'b1, 1'b0);
    drive_line(202, 1'b1, 1'b0);
    check("err_drain", 32'(err_cnt - err_base), 32'd1);

    // Reset in the middle of a fetch
    err_base = err_cnt;
    drive_line(300, 1'b1, 1'b1);
    drive_line(301, 1'b1, 1'b0);
    drive_line(302, 1'b1, 1'b0);
    check("err_reset", 32'(err_cnt - err_base), 32'd0);

    @(negedge clk);
    stim_on = 1'b0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
